ras: RTL

- Return address stack for the fetch predictor stage.
- Supplies predicted return targets for return-type control flow.
- Pushes link addresses for call-type control flow.
- Exposes its top-of-stack index and count so branch checkpoints can snapshot them, and restores them on mispredict or flush.
- Sits beside the BTB/UPCT lookup in fetch; the fetch-redirect logic consumes its outputs.

---
 rtl/ras.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ras.sv
// Return address stack for the fetch predictor: circular call/return target stack
// with checkpoint restore. Optional perf counters are built when RAS_PERF_COUNTERS_EN is defined.
module ras #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       link_valid,
    input  logic [31:0]                link_pc,
    input  logic                       ret_valid,
    output logic                       ret_present,
    output logic [31:0]                ret_target,
    output logic [RAS_INDEX_WIDTH-1:0] ras_index,
    output logic [RAS_INDEX_WIDTH:0]   ras_count,
    input  logic                       update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0] update_ras_index,
    input  logic [RAS_INDEX_WIDTH:0]   update_ras_count
`ifdef RAS_PERF_COUNTERS_EN
    ,
    output logic [15:0]                perf_overflow_count,
    output logic [15:0]                perf_underflow_count
`endif
);

    localparam int IW = RAS_INDEX_WIDTH;
    localparam int CW = RAS_INDEX_WIDTH + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_ENTRIES);

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_RESTORE
    } op_e;

    logic [RAS_TARGET_WIDTH-1:0] stack [RAS_ENTRIES];
    logic [IW-1:0]               ptr;
    logic [CW-1:0]               count;

    logic [IW-1:0]               top_idx;
    logic                        empty;
    logic                        full;
    op_e                         op;

    logic [IW-1:0]               ptr_nxt;
    logic [CW-1:0]               count_nxt;
    logic                        wr_en;
    logic [IW-1:0]               wr_idx;
    logic [RAS_TARGET_WIDTH-1:0] wr_data;

    assign top_idx     = ptr - 1'b1;
    assign empty       = (count == '0);
    assign full        = (count == FULL_COUNT);

    assign ret_present = !empty;
    assign ret_target  = {stack[top_idx], 1'b0};
    assign ras_index   = ptr;
    assign ras_count   = count;

    // A swap on an empty stack degenerates to a push; a pop on an empty stack does nothing.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        op = OP_NONE;
        if (update_valid) begin
            op = OP_RESTORE;
        end else if (link_valid && ret_valid) begin
            op = empty ? OP_PUSH : OP_SWAP;
        end else if (link_valid) begin
            op = OP_PUSH;
        end else if (ret_valid && !empty) begin
            op = OP_POP;
        end
    end

    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = ptr;
        wr_data   = link_pc[31:1];
        case (op)
            OP_PUSH: begin
                wr_en     = 1'b1;
                wr_idx    = ptr;
                ptr_nxt   = ptr + 1'b1;
                count_nxt = full ? count : count + 1'b1;
            end
            OP_POP: begin
                ptr_nxt   = top_idx;
                count_nxt = count - 1'b1;
            end
            OP_SWAP: begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
            OP_RESTORE: begin
                ptr_nxt   = update_ras_index;
                count_nxt = update_ras_count;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
        end
    end

    // NOTE: the stack entries are reset because a restored pointer may expose any slot as the top.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack[i] <= '0;
            end
        end else if (wr_en) begin
            stack[wr_idx] <= wr_data;
        end
    end

`ifdef RAS_PERF_COUNTERS_EN
    logic overflow_evt;
    logic underflow_evt;

    // Only plain pushes and pops count; a restore drops the request, so nothing is recorded.
    assign overflow_evt  = link_valid && !ret_valid && !update_valid && full;
    assign underflow_evt = ret_valid && !link_valid && !update_valid && empty;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_overflow_count  <= '0;
            perf_underflow_count <= '0;
        end else begin
            if (overflow_evt && perf_overflow_count != 16'hFFFF) begin
                perf_overflow_count <= perf_overflow_count + 16'd1;
            end
            if (underflow_evt && perf_underflow_count != 16'hFFFF) begin
                perf_underflow_count <= perf_underflow_count + 16'd1;
            end
        end
    end
`endif

    restore_count_legal: assert property (
        @(posedge CLK) disable iff (!nRST)
        update_valid |-> (update_ras_count <= FULL_COUNT)
    );

endmodule
